// File: rtl/gpio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_pkg : shared types and helpers for the GPIO input conditioning path   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gpio_pkg;

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_BOTH  = 2'b10,
    MODE_LEVEL = 2'b11
  } irq_mode_e;

  function automatic logic mode_event(
    input irq_mode_e mode,
    input logic      rise,
    input logic      fall,
    input logic      level
  );
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_RISE:  hit = rise;
      MODE_FALL:  hit = fall;
      MODE_BOTH:  hit = rise | fall;
      MODE_LEVEL: hit = level;
    endcase
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_in_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_in_chan : one pin - synchroniser, enable settle, debounce, event      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gpio_in_chan
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin_en,
  input  logic             input_val,
  input  logic [DEB_W-1:0] deb_limit,
  input  logic [1:0]       irq_mode,
  output logic             pin_state,
  output logic             evt
);

  localparam int SETTLE_LEN = SYNC_STAGES + 1;
  localparam int SETTLE_W   = $clog2(SETTLE_LEN + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SETTLE_LEN);
  localparam logic [DEB_W-1:0]    CNT_MAX     = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SETTLE_W-1:0]    settle_q, settle_d;
  logic [DEB_W-1:0]       cnt_q, cnt_d;
  logic                   pin_state_q, pin_state_d;
  logic                   prev_q, prev_d;
  logic                   sync_out;
  logic                   settled;
  logic                   rise, fall, level;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign settled  = pin_en && (settle_q == SETTLE_DONE);

  always_comb begin
    sync_d      = '0;
    settle_d    = '0;
    cnt_d       = '0;
    pin_state_d = 1'b0;
    prev_d      = 1'b0;
    if (pin_en) begin
      sync_d = {sync_q[SYNC_STAGES-2:0], input_val};
      if (!settled) begin
        // Follow the synchroniser directly and keep prev in step so no edge is seen.
        settle_d    = settle_q + 1'b1;
        pin_state_d = sync_out;
        prev_d      = sync_out;
      end else begin
        settle_d    = settle_q;
        prev_d      = pin_state_q;
        pin_state_d = pin_state_q;
        if (sync_out != pin_state_q) begin
          if (cnt_q >= deb_limit) begin
            pin_state_d = sync_out;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      settle_q    <= '0;
      cnt_q       <= '0;
      pin_state_q <= 1'b0;
      prev_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      pin_state_q <= pin_state_d;
      prev_q      <= prev_d;
    end
  end

  assign rise  = settled &  pin_state_q & ~prev_q;
  assign fall  = settled & ~pin_state_q &  prev_q;
  assign level = settled &  pin_state_q;

  assign evt       = mode_event(irq_mode_e'(irq_mode), rise, fall, level);
  assign pin_state = pin_state_q;

endmodule
`default_nettype wire

// File: rtl/gpio_in_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_in_filter : N-pin input conditioning with sticky interrupt pending    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gpio_in_filter
  import gpio_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     pin_en,
  output logic [N-1:0]     input_en,
  input  logic [N-1:0]     input_val,
  input  logic [DEB_W-1:0] deb_limit,
  input  logic [2*N-1:0]   irq_mode,
  input  logic [N-1:0]     irq_en,
  input  logic [N-1:0]     irq_clr,
  output logic [N-1:0]     pin_state,
  output logic [N-1:0]     irq_pend,
  output logic             irq
);

  logic [N-1:0] evt;
  logic [N-1:0] irq_pend_q, irq_pend_d;

  assign input_en = pin_en;

  for (genvar i = 0; i < N; i++) begin : g_chan
    gpio_in_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_W       (DEB_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin_en    (pin_en[i]),
      .input_val (input_val[i]),
      .deb_limit (deb_limit),
      .irq_mode  (irq_mode[2*i+1:2*i]),
      .pin_state (pin_state[i]),
      .evt       (evt[i])
    );
  end

  // A new event beats a coincident clear so it is never lost.
  always_comb begin
    irq_pend_d = (irq_pend_q & ~irq_clr) | (evt & irq_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend_q <= '0;
    end else begin
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_pend = irq_pend_q;
  assign irq      = |(irq_pend_q & irq_en);

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gpio_in_filter : scoreboard bench with a cycle-level reference model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_gpio_in_filter;
  import gpio_pkg::*;

  localparam int N  = 8;
  localparam int S  = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  pin_en, input_en, input_val, irq_en, irq_clr, pin_state, irq_pend;
  logic [DW-1:0] deb_limit;
  logic [2*N-1:0] irq_mode;
  logic          irq;

  always #5 clk = ~clk;

  gpio_in_filter #(.N(N), .SYNC_STAGES(S), .DEB_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pin_en    (pin_en),
    .input_en  (input_en),
    .input_val (input_val),
    .deb_limit (deb_limit),
    .irq_mode  (irq_mode),
    .irq_en    (irq_en),
    .irq_clr   (irq_clr),
    .pin_state (pin_state),
    .irq_pend  (irq_pend),
    .irq       (irq)
  );

  typedef struct packed {
    logic [N-1:0] st;
    logic [N-1:0] pend;
    logic         irq;
    logic [N-1:0] ien;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: chain holds the last S sampled pad words, oldest first.
  logic [N-1:0] m_chain[$];
  logic [N-1:0] m_state, m_prev, m_pend;
  int           m_age[N];
  int           m_run[N];

  task automatic model_step();
    logic [N-1:0] so, evt, new_pend;
    logic         settled, rise, fall;
    irq_mode_e    md;
    exp_t         e;
    evt = '0;
    if (!rst_n) begin
      m_chain = {};
      for (int k = 0; k < S; k++) m_chain.push_back('0);
      m_state = '0;
      m_prev  = '0;
      m_pend  = '0;
      for (int i = 0; i < N; i++) begin
        m_age[i] = 0;
        m_run[i] = 0;
      end
    end else begin
      so = m_chain[0];
      for (int i = 0; i < N; i++) begin
        settled = pin_en[i] && (m_age[i] >= S + 1);
        rise = settled && m_state[i] && !m_prev[i];
        fall = settled && !m_state[i] && m_prev[i];
        md   = irq_mode_e'(irq_mode[2*i +: 2]);
        if (md == MODE_RISE)       evt[i] = rise;
        else if (md == MODE_FALL)  evt[i] = fall;
        else if (md == MODE_BOTH)  evt[i] = rise || fall;
        else                       evt[i] = settled && m_state[i];
      end
      new_pend = (m_pend & ~irq_clr) | (evt & irq_en);
      for (int i = 0; i < N; i++) begin
        if (!pin_en[i]) begin
          m_age[i] = 0; m_run[i] = 0; m_state[i] = 1'b0; m_prev[i] = 1'b0;
        end else if (m_age[i] < S + 1) begin
          m_age[i]++;
          m_run[i]   = 0;
          m_state[i] = so[i];
          m_prev[i]  = so[i];
        end else begin
          m_prev[i] = m_state[i];
          if (so[i] != m_state[i]) begin
            if (m_run[i] >= int'(deb_limit)) begin
              m_state[i] = so[i];
              m_run[i]   = 0;
            end else if (m_run[i] < 255) begin
              m_run[i]++;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_chain.push_back(input_val & pin_en);
      void'(m_chain.pop_front());
      for (int k = 0; k < m_chain.size(); k++) m_chain[k] = m_chain[k] & pin_en;
      m_pend = new_pend;
    end
    e.st   = m_state;
    e.pend = m_pend;
    e.irq  = |(m_pend & irq_en);
    e.ien  = pin_en;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      model_step();
      @(negedge clk);
    end
  endtask

  // Monitor: every clock edge the DUT presents a fresh output word.
  initial begin : monitor
    exp_t e;
    logic bad;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        bad = 1'b0;
        n_vec++;
        if (pin_state !== e.st) begin
          $display("FAIL pin_state t=%0t got %h exp %h", $time, pin_state, e.st); bad = 1'b1;
        end
        if (irq_pend !== e.pend) begin
          $display("FAIL irq_pend t=%0t got %h exp %h", $time, irq_pend, e.pend); bad = 1'b1;
        end
        if (irq !== e.irq) begin
          $display("FAIL irq t=%0t got %b exp %b", $time, irq, e.irq); bad = 1'b1;
        end
        if (input_en !== e.ien) begin
          $display("FAIL input_en t=%0t got %h exp %h", $time, input_en, e.ien); bad = 1'b1;
        end
        if (bad) n_err++;
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; pin_en = '0; input_val = '0; deb_limit = '0;
    irq_mode = '0; irq_en = '0; irq_clr = '0;
    tick(3);

    // Enable with pads already high: settles to high, no edge event.
    rst_n = 1'b1; pin_en = 8'hFF; input_val = 8'hFF; irq_en = 8'hFF;
    tick(8);
    deb_limit = 8'd3;
    input_val = 8'h00;
    tick(10);
    irq_mode = {2'(MODE_RISE), 2'(MODE_RISE), 2'(MODE_FALL), 2'(MODE_RISE),
                2'(MODE_LEVEL), 2'(MODE_BOTH), 2'(MODE_RISE), 2'(MODE_RISE)};
    irq_en = 8'hEF;
    tick(2);

    // Clean rise on pin0.
    input_val[0] = 1'b1; tick(10);

    // Pin1: 3-cycle glitch rejected, 4-cycle pulse accepted.
    input_val[1] = 1'b1; tick(3); input_val[1] = 1'b0; tick(10);
    input_val[1] = 1'b1; tick(4); input_val[1] = 1'b0; tick(10);

    // Pin2 BOTH: clear after first event, clear coincident with the second.
    input_val[2] = 1'b1; tick(10);
    irq_clr[2] = 1'b1; tick(1); irq_clr[2] = 1'b0; tick(2);
    input_val[2] = 1'b0; tick(6);
    irq_clr[2] = 1'b1; tick(1); irq_clr[2] = 1'b0; tick(3);

    // Pin3 LEVEL: clear while high, then clear while low.
    input_val[3] = 1'b1; tick(10);
    irq_clr[3] = 1'b1; tick(1); irq_clr[3] = 1'b0; tick(3);
    input_val[3] = 1'b0; tick(10);
    irq_clr[3] = 1'b1; tick(1); irq_clr[3] = 1'b0; tick(3);

    // Pin4 masked edge; pin5 disabled while high gives no fall.
    input_val[4] = 1'b1; tick(10);
    input_val[5] = 1'b1; tick(10);
    pin_en[5] = 1'b0; tick(4);
    pin_en[5] = 1'b1; tick(8);

    // Reset in the middle of activity.
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(8);

    deb_limit = 8'd0;
    input_val[6] = 1'b1; tick(5);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) input_val[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0) deb_limit = DW'($urandom_range(0, 6));
      if ($urandom_range(0, 199) == 0) irq_mode = 16'($urandom);
      if ($urandom_range(0, 149) == 0) irq_en = 8'($urandom);
      if ($urandom_range(0, 149) == 0) pin_en[$urandom_range(0, N-1)] ^= 1'b1;
      irq_clr = 8'($urandom & $urandom & $urandom);
      rst_n = ($urandom_range(0, 999) != 0);
      tick(1);
    end
    rst_n = 1'b1; irq_clr = '0;
    tick(2);

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain left %0d exp 0", sb.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
